// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: capture FSM state encoding and the default counter resolution.
package pwm_pkg;

  // Counter/result width used by both the generator and the capture block.
  localparam int PWM_RESOLUTION = 16;

  typedef enum logic [1:0] {
    PWM_CAP_IDLE    = 2'd0,
    PWM_CAP_ARM     = 2'd1,
    PWM_CAP_MEASURE = 2'd2
  } pwm_cap_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes an asynchronous pin and produces registered rise/fall strobes.
// Latency: a pin change sampled at edge N appears on rise/fall after edge N+SyncStages.
// Backpressure: none; the strobes are single-cycle and always produced.
// Ports: clk, rst_n (sync, active-low), async_i (raw pin),
//        level_o (synchronized level), rise_o / fall_o (1-cycle edge strobes).
module pwm_edge_sync #(
  parameter int SyncStages = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], async_i};
      prev_q <= sync_q[SyncStages-1];
      // Strobes are registered so the FSM sees clean, glitch-free edges.
      rise_o <= sync_q[SyncStages-1] & ~prev_q;
      fall_o <= ~sync_q[SyncStages-1] & prev_q;
    end
  end

  assign level_o = sync_q[SyncStages-1];

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an incoming PWM waveform in clk cycles.
// Latency: pin first sampled high at edge N -> valid_o after edge N+SyncStages+1.
// Backpressure: one result is held until valid_o & ready_i; a newer capture
//   overwrites it and sets the sticky missed_o flag.
// Ports: clk, rst_n (sync, active-low), enable, pwm_in (async pin),
//   period_o / high_time_o (result), valid_o / ready_i (handshake),
//   missed_o (sticky overwrite flag), timeout_o (1-cycle saturation pulse).
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int Resolution = PWM_RESOLUTION,
  parameter int SyncStages = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  pwm_in,
  output logic [Resolution-1:0] period_o,
  output logic [Resolution-1:0] high_time_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  missed_o,
  output logic                  timeout_o
);

  localparam logic [Resolution-1:0] CntOne = {{(Resolution-1){1'b0}}, 1'b1};
  // The step that would take cnt to all-ones is treated as saturation.
  localparam logic [Resolution-1:0] CntPreSat = {{(Resolution-1){1'b1}}, 1'b0};

  pwm_cap_state_e        state;
  logic [Resolution-1:0] cnt;
  logic [Resolution-1:0] hi_lat;
  logic                  rise;
  logic                  fall;
  // The FSM works purely from the edge strobes; the level is not needed here.
  logic                  pin_level_unused;

  pwm_edge_sync #(
    .SyncStages(SyncStages)
  ) u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(pwm_in),
    .level_o(pin_level_unused),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= PWM_CAP_IDLE;
      cnt         <= '0;
      hi_lat      <= '0;
      period_o    <= '0;
      high_time_o <= '0;
      valid_o     <= 1'b0;
      missed_o    <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      timeout_o <= 1'b0;

      // Consume first; a capture in the same cycle below re-asserts valid_o.
      if (valid_o && ready_i) begin
        valid_o  <= 1'b0;
        missed_o <= 1'b0;
      end

      if (!enable) begin
        state    <= PWM_CAP_IDLE;
        cnt      <= '0;
        hi_lat   <= '0;
        valid_o  <= 1'b0;
        missed_o <= 1'b0;
      end else begin
        case (state)
          PWM_CAP_IDLE: begin
            state <= PWM_CAP_ARM;
          end

          PWM_CAP_ARM: begin
            // First rise only starts timing; there is no prior period to report.
            if (rise) begin
              cnt    <= CntOne;
              hi_lat <= '0;
              state  <= PWM_CAP_MEASURE;
            end
          end

          PWM_CAP_MEASURE: begin
            if (rise) begin
              period_o    <= cnt;
              high_time_o <= hi_lat;
              valid_o     <= 1'b1;
              cnt         <= CntOne;
              hi_lat      <= '0;
              // Overwriting an unread result is only a miss if it is not
              // being consumed in this very cycle.
              if (valid_o && !ready_i) begin
                missed_o <= 1'b1;
              end
            end else begin
              cnt <= cnt + CntOne;
              if (fall) begin
                hi_lat <= cnt;
              end
              // Input stuck or too slow: drop the partial measurement and
              // wait for a fresh rise. Any held result stays untouched.
              if (cnt == CntPreSat) begin
                timeout_o <= 1'b1;
                state     <= PWM_CAP_ARM;
              end
            end
          end

          default: begin
            state <= PWM_CAP_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        pwm_in;
  logic        ready;
  logic [15:0] period;
  logic [15:0] high_time;
  logic        valid;
  logic        missed;
  logic        timeout;

  logic        en8;
  logic        pwm8;
  logic        rdy8;
  logic [7:0]  period8;
  logic [7:0]  high8;
  logic        valid8;
  logic        missed8;
  logic        timeout8;

  int total = 0;
  int bad   = 0;

  // simple PWM waveform generator driven from the stimulus thread
  int gen_p  = 10;
  int gen_h  = 3;
  int ph     = 0;
  bit gen_on = 0;

  typedef struct {
    int p;
    int h;
    int exp_period;
    int exp_high;
  } vec_t;

  vec_t vecs[5];

  pwm_capture #(.Resolution(16), .SyncStages(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .period_o   (period),
    .high_time_o(high_time),
    .valid_o    (valid),
    .ready_i    (ready),
    .missed_o   (missed),
    .timeout_o  (timeout)
  );

  pwm_capture #(.Resolution(8), .SyncStages(2)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (en8),
    .pwm_in     (pwm8),
    .period_o   (period8),
    .high_time_o(high8),
    .valid_o    (valid8),
    .ready_i    (rdy8),
    .missed_o   (missed8),
    .timeout_o  (timeout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and drive the generator output there.
  task automatic tick();
    @(negedge clk);
    if (gen_on) begin
      pwm_in = (ph < gen_h);
      ph = (ph + 1 == gen_p) ? 0 : ph + 1;
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    gen_on = 0;
    pwm_in = 1'b0;
    ph     = 0;
    enable = 1'b0;
    ready  = 1'b1;
    tick();
    tick();
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    chk("rst_valid", valid, 0);
    chk("rst_missed", missed, 0);
    chk("rst_timeout", timeout, 0);
    rst_n = 1'b1;
  endtask

  // Reset, enable, let the FSM reach ARM, then start the waveform at tick 0.
  task automatic start(input int p, input int h, input logic rdy);
    do_reset();
    enable = 1'b1;
    ready  = rdy;
    tick();
    tick();
    tick();
    gen_p  = p;
    gen_h  = h;
    ph     = 0;
    gen_on = 1;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    pwm_in = 1'b0;
    ready  = 1'b1;
    en8    = 1'b0;
    pwm8   = 1'b0;
    rdy8   = 1'b0;

    // Table: first result appears at tick p+4 (second rise + 3-cycle pipeline).
    vecs[0] = '{p: 10, h: 3,  exp_period: 10, exp_high: 3};
    vecs[1] = '{p: 7,  h: 1,  exp_period: 7,  exp_high: 1};
    vecs[2] = '{p: 2,  h: 1,  exp_period: 2,  exp_high: 1};
    vecs[3] = '{p: 12, h: 11, exp_period: 12, exp_high: 11};
    vecs[4] = '{p: 30, h: 15, exp_period: 30, exp_high: 15};

    for (int v = 0; v < 5; v++) begin
      start(vecs[v].p, vecs[v].h, 1'b1);
      for (int k = 0; k <= vecs[v].p + 5; k++) begin
        tick();
        chk("tbl_valid", valid, (k == vecs[v].p + 4) ? 1 : 0);
        if (k == vecs[v].p + 4) begin
          chk("tbl_period", period, vecs[v].exp_period);
          chk("tbl_high", high_time, vecs[v].exp_high);
          chk("tbl_missed", missed, 0);
        end
      end
    end

    // Steady stream with ready=1: a 1-cycle valid every period.
    start(10, 3, 1'b1);
    for (int k = 0; k <= 45; k++) begin
      tick();
      chk("stream_valid", valid, (k >= 14 && (k - 14) % 10 == 0) ? 1 : 0);
      if (valid) begin
        chk("stream_period", period, 10);
        chk("stream_high", high_time, 3);
      end
    end

    // Overwrite while stalled sets missed; consume clears both.
    start(10, 3, 1'b0);
    for (int k = 0; k <= 26; k++) begin
      tick();
      if (k == 5) gen_h = 6;
      if (k == 14) begin
        chk("ovr_valid1", valid, 1);
        chk("ovr_high1", high_time, 3);
        chk("ovr_missed1", missed, 0);
      end
      if (k == 24) begin
        chk("ovr_valid2", valid, 1);
        chk("ovr_period2", period, 10);
        chk("ovr_high2", high_time, 6);
        chk("ovr_missed2", missed, 1);
        ready = 1'b1;
      end
      if (k == 25) begin
        chk("ovr_valid_clr", valid, 0);
        chk("ovr_missed_clr", missed, 0);
      end
    end

    // Capture in the same cycle as a consume.
    start(10, 3, 1'b1);
    for (int k = 0; k <= 35; k++) begin
      tick();
      if (k == 15) begin
        chk("cc_valid15", valid, 0);
        ready = 1'b0;
        gen_h = 5;
      end
      if (k == 24) begin
        chk("cc_valid24", valid, 1);
        chk("cc_high24", high_time, 3);
        chk("cc_missed24", missed, 0);
      end
      if (k == 33) begin
        chk("cc_valid33", valid, 1);
        ready = 1'b1;
      end
      if (k == 34) begin
        chk("cc_valid34", valid, 1);
        chk("cc_period34", period, 10);
        chk("cc_high34", high_time, 5);
        chk("cc_missed34", missed, 0);
      end
      if (k == 35) begin
        chk("cc_valid35", valid, 0);
        chk("cc_missed35", missed, 0);
      end
    end

    // Disable mid-measure with a result and missed flag pending.
    start(10, 3, 1'b0);
    for (int k = 0; k <= 44; k++) begin
      tick();
      if (k == 24) chk("dis_missed_pre", missed, 1);
      if (k == 26) enable = 1'b0;
      if (k == 27) begin
        chk("dis_valid", valid, 0);
        chk("dis_missed", missed, 0);
      end
      if (k == 28) enable = 1'b1;
      if (k > 27 && k < 44) chk("dis_novalid", valid, 0);
      if (k == 44) begin
        chk("dis_valid44", valid, 1);
        chk("dis_period44", period, 10);
        chk("dis_high44", high_time, 3);
      end
    end

    // Reset pulse mid-period.
    start(10, 3, 1'b0);
    for (int k = 0; k <= 34; k++) begin
      tick();
      if (k == 16) begin
        chk("mr_valid16", valid, 1);
        rst_n = 1'b0;
      end
      if (k == 17) begin
        chk("mr_period", period, 0);
        chk("mr_high", high_time, 0);
        chk("mr_valid", valid, 0);
        chk("mr_missed", missed, 0);
        chk("mr_timeout", timeout, 0);
        rst_n = 1'b1;
      end
      if (k > 17 && k < 34) chk("mr_novalid", valid, 0);
      if (k == 34) begin
        chk("mr_valid34", valid, 1);
        chk("mr_period34", period, 10);
        chk("mr_high34", high_time, 3);
      end
    end

    // Saturation on the 8-bit instance: pin held high after a rise.
    gen_on = 0;
    en8    = 1'b1;
    rdy8   = 1'b1;
    tick();
    tick();
    tick();
    for (int k = 0; k <= 336; k++) begin
      tick();
      if (k < 300)      pwm8 = 1'b1;
      else if (k < 310) pwm8 = 1'b0;
      else              pwm8 = ((k - 310) % 20) < 8;
      if (k >= 1 && k <= 300) chk("sat_timeout", timeout8, (k == 258) ? 1 : 0);
      chk("sat_valid", valid8, (k == 334) ? 1 : 0);
      if (k == 334) begin
        chk("sat_period", period8, 20);
        chk("sat_high", high8, 8);
        chk("sat_missed", missed8, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
